// File: rtl/vec_pkg.sv
// Shared constants, opcode and FSM encodings for the SIMD vector execute stage.
package vec_pkg;

    localparam int LANES  = 6;
    localparam int LANE_W = 8;
    localparam int VW     = LANES * LANE_W;
    localparam int NREGS  = 11;
    localparam int ADDR_W = 4;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_PASS = 3'b110,
        OP_NOP  = 3'b111
    } vop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A destination is writable only if it names an existing architectural register.
    function automatic logic dst_ok(input logic [ADDR_W-1:0] d, input int nregs);
        return ({{(32-ADDR_W){1'b0}}, d} < nregs);
    endfunction

endpackage

// File: rtl/vec_execute_if.sv
// Operation-issue and register-file writeback bundle of the vector execute stage.
interface vec_execute_if;
    import vec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] dst;
    logic [VW-1:0]     src_a;
    logic [VW-1:0]     src_b;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [VW-1:0]     wb_data;
    logic              bad_dst;

    modport master (
        output in_valid, op, dst, src_a, src_b,
        input  in_ready, wb_we, wb_addr, wb_data, bad_dst
    );

    modport slave (
        input  in_valid, op, dst, src_a, src_b,
        output in_ready, wb_we, wb_addr, wb_data, bad_dst
    );

endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; multiply is handled by the shared multiplier in the top.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int W = LANE_W
) (
    input  vop_t         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_execute.sv
// SIMD vector execute stage: single-cycle lane-wise logic/arithmetic and a
// lane-serial multiply through one shared LANE_W x LANE_W multiplier.
module vec_execute #(
    parameter int LANES  = vec_pkg::LANES,
    parameter int LANE_W = vec_pkg::LANE_W,
    parameter int NREGS  = vec_pkg::NREGS
) (
    input  logic          clk,
    input  logic          reset,
    vec_execute_if.slave  bus
);
    import vec_pkg::*;

    localparam int VEC_W = LANES * LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  lane_cnt_q, lane_cnt_d;
    logic [VEC_W-1:0]  a_q,        a_d;
    logic [VEC_W-1:0]  b_q,        b_d;
    logic [VEC_W-1:0]  mul_res_q,  mul_res_d;
    logic [ADDR_W-1:0] mul_dst_q,  mul_dst_d;
    logic              wb_we_q,    wb_we_d;
    logic [ADDR_W-1:0] wb_addr_q,  wb_addr_d;
    logic [VEC_W-1:0]  wb_data_q,  wb_data_d;
    logic              bad_dst_q,  bad_dst_d;

    vop_t              op_in;
    logic [VEC_W-1:0]  alu_y;
    logic [LANE_W-1:0] mul_a;
    logic [LANE_W-1:0] mul_b;
    logic [LANE_W-1:0] mul_lo;

    assign op_in = vop_t'(bus.op);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            vec_lane_alu #(.W(LANE_W)) u_alu (
                .op (op_in),
                .a  (bus.src_a[gi*LANE_W +: LANE_W]),
                .b  (bus.src_b[gi*LANE_W +: LANE_W]),
                .y  (alu_y[gi*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // Operands shift down one lane per MUL cycle so the multiplier always sees lane 0.
    assign mul_a  = a_q[LANE_W-1:0];
    assign mul_b  = b_q[LANE_W-1:0];
    assign mul_lo = mul_a * mul_b;

    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        mul_res_d  = mul_res_q;
        mul_dst_d  = mul_dst_q;
        wb_we_d    = 1'b0;
        bad_dst_d  = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    case (op_in)
                        OP_NOP: ;
                        OP_MUL: begin
                            state_d    = ST_MUL;
                            lane_cnt_d = '0;
                            a_d        = bus.src_a;
                            b_d        = bus.src_b;
                            mul_dst_d  = bus.dst;
                        end
                        default: begin
                            if (dst_ok(bus.dst, NREGS)) begin
                                wb_we_d   = 1'b1;
                                wb_addr_d = bus.dst;
                                wb_data_d = alu_y;
                            end else begin
                                bad_dst_d = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_MUL: begin
                // Products enter at the top and drift down, landing in lane order.
                mul_res_d = mul_res_q >> LANE_W;
                mul_res_d[VEC_W-1 -: LANE_W] = mul_lo;
                a_d = a_q >> LANE_W;
                b_d = b_q >> LANE_W;
                if (lane_cnt_q == LAST_LANE) begin
                    state_d    = ST_DONE;
                    lane_cnt_d = '0;
                    if (dst_ok(mul_dst_q, NREGS)) begin
                        wb_we_d   = 1'b1;
                        wb_addr_d = mul_dst_q;
                        wb_data_d = mul_res_d;
                    end else begin
                        bad_dst_d = 1'b1;
                    end
                end else begin
                    lane_cnt_d = lane_cnt_q + 1'b1;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lane_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mul_res_q  <= '0;
            mul_dst_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            bad_dst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            mul_res_q  <= mul_res_d;
            mul_dst_q  <= mul_dst_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            bad_dst_q  <= bad_dst_d;
        end
    end

    // Reset masks a pending pulse so an aborted DONE never reaches the register file.
    assign bus.in_ready = (state_q == ST_IDLE);
    assign bus.wb_we    = wb_we_q & ~reset;
    assign bus.bad_dst  = bad_dst_q & ~reset;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;

endmodule

// File: tb/tb_vec_execute.sv
// Directed bench for vec_execute: hand-computed vectors checked with immediate assertions.
module tb_vec_execute;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vec_execute_if bus();

    vec_execute #(.LANES(LANES), .LANE_W(LANE_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input vop_t op, input logic [3:0] dst,
                         input logic [47:0] a, input logic [47:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dst      = dst;
        bus.src_a    = a;
        bus.src_b    = b;
    endtask

    task automatic show(input string name);
        $display("txn %-8s wb_we=%0b bad_dst=%0b wb_addr=%0d wb_data=%h",
                 name, bus.wb_we, bus.bad_dst, bus.wb_addr, bus.wb_data);
    endtask

    int          acc_k;
    int          nw;
    int          wcyc[2];
    logic [3:0]  waddr[2];
    logic [47:0] wdat[2];

    initial begin
        // Reset with a simultaneous offer: the offer must be dropped.
        reset = 1'b1;
        issue(OP_ADD, 4'd4, 48'h1, 48'h1);
        tick();
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        show("reset");
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_wb_we",    bus.wb_we,    1'b0);
        chk("rst_bad_dst",  bus.bad_dst,  1'b0);
        chk("rst_wb_addr",  bus.wb_addr,  4'd0);
        chk("rst_wb_data",  bus.wb_data,  48'h0);

        // ADD with lane-5 wrap
        issue(OP_ADD, 4'd3, 48'hFF01_0203_0405, 48'h0101_0101_0101);
        chk("add_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        show("add");
        chk("add_wb_we",   bus.wb_we,   1'b1);
        chk("add_wb_addr", bus.wb_addr, 4'd3);
        chk("add_wb_data", bus.wb_data, 48'h0002_0304_0506);
        tick();
        chk("idle_wb_we",   bus.wb_we,   1'b0);
        chk("idle_wb_hold", bus.wb_data, 48'h0002_0304_0506);

        // SUB with contained borrow
        issue(OP_SUB, 4'd1, 48'h0, 48'h0000_0000_0001);
        tick();
        bus.in_valid = 1'b0;
        show("sub");
        chk("sub_wb_we",   bus.wb_we,   1'b1);
        chk("sub_wb_addr", bus.wb_addr, 4'd1);
        chk("sub_wb_data", bus.wb_data, 48'h0000_0000_00FF);

        // OR to register 0
        issue(OP_OR, 4'd0, 48'h1200_0000_00F0, 48'h0034_0000_000F);
        tick();
        bus.in_valid = 1'b0;
        show("or");
        chk("or_wb_we",   bus.wb_we,   1'b1);
        chk("or_wb_addr", bus.wb_addr, 4'd0);
        chk("or_wb_data", bus.wb_data, 48'h1234_0000_00FF);

        // MUL: busy 7 cycles, single write at N+7
        issue(OP_MUL, 4'd2, 48'h0203_0405_1011, 48'h0302_0203_1010);
        chk("mul_in_ready0", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        bus.src_a    = 48'hFFFF_FFFF_FFFF;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("mul_busy_k%0d", k), bus.in_ready, 1'b0);
            if (k == 3) chk("mul_hold_data", bus.wb_data, 48'h1234_0000_00FF);
            if (k == 7) begin
                show("mul");
                chk("mul_wb_we",   bus.wb_we,   1'b1);
                chk("mul_wb_addr", bus.wb_addr, 4'd2);
                chk("mul_wb_data", bus.wb_data, 48'h0606_080F_0010);
            end else begin
                chk($sformatf("mul_no_we_k%0d", k), bus.wb_we, 1'b0);
            end
            tick();
        end
        chk("mul_ready_after", bus.in_ready, 1'b1);
        chk("mul_we_after",    bus.wb_we,    1'b0);

        // NOP: consumed, nothing written
        issue(OP_NOP, 4'd4, 48'h5, 48'h6);
        tick();
        bus.in_valid = 1'b0;
        show("nop");
        chk("nop_wb_we",    bus.wb_we,    1'b0);
        chk("nop_bad_dst",  bus.bad_dst,  1'b0);
        chk("nop_in_ready", bus.in_ready, 1'b1);

        // XOR to dst 11 (rejected) then AND to dst 10, back-to-back
        issue(OP_XOR, 4'd11, 48'h0F0F_0F0F_0F0F, 48'h1111_1111_1111);
        tick();
        show("xor_bad");
        chk("xor_bad_dst", bus.bad_dst, 1'b1);
        chk("xor_wb_we",   bus.wb_we,   1'b0);
        chk("xor_addr_hold", bus.wb_addr, 4'd2);
        issue(OP_AND, 4'd10, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_0F0F);
        tick();
        bus.in_valid = 1'b0;
        show("and");
        chk("and_wb_we",   bus.wb_we,   1'b1);
        chk("and_bad_dst", bus.bad_dst, 1'b0);
        chk("and_wb_addr", bus.wb_addr, 4'd10);
        chk("and_wb_data", bus.wb_data, 48'hF000_F000_0000);

        // Reset at cycle N+3 of a MUL aborts it
        issue(OP_MUL, 4'd5, 48'h0303_0303_0303, 48'h0505_0505_0505);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        show("mul_abort");
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_wb_data",  bus.wb_data,  48'h0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("abort_we_k%0d", k),  bus.wb_we,   1'b0);
            chk($sformatf("abort_bad_k%0d", k), bus.bad_dst, 1'b0);
            tick();
        end

        // ADD held during a MUL: accepted on first IDLE cycle, writes 2 cycles after MUL
        issue(OP_MUL, 4'd6, 48'h0101_0101_0101, 48'h0202_0202_0202);
        tick();
        issue(OP_ADD, 4'd7, 48'h7F80_0000_0001, 48'h0180_0000_00FF);
        acc_k = -1;
        nw    = 0;
        wcyc[0] = -1; wcyc[1] = -1;
        waddr[0] = '0; waddr[1] = '0;
        wdat[0] = '0; wdat[1] = '0;
        for (int k = 1; k <= 14; k++) begin
            if (bus.wb_we && nw < 2) begin
                wcyc[nw]  = k;
                waddr[nw] = bus.wb_addr;
                wdat[nw]  = bus.wb_data;
                nw++;
                show("held_wr");
            end
            if (bus.in_valid && bus.in_ready) acc_k = k;
            tick();
            if (acc_k == k) bus.in_valid = 1'b0;
        end
        chk("held_accept_cycle", acc_k, 8);
        chk("held_mul_cycle",    wcyc[0], 7);
        chk("held_mul_addr",     waddr[0], 4'd6);
        chk("held_mul_data",     wdat[0], 48'h0202_0202_0202);
        chk("held_add_cycle",    wcyc[1], 9);
        chk("held_add_addr",     waddr[1], 4'd7);
        chk("held_add_data",     wdat[1], 48'h8000_0000_0000);
        chk("held_gap",          wcyc[1] - wcyc[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_execute.md
VEC_EXECUTE -- requirements
Module: vec_execute

Interface
REQ-001 Parameter LANES, default 6, number of SIMD lanes per vector word.
REQ-002 Parameter LANE_W, default 8, bits per lane; vector width VW = LANES*LANE_W = 48.
REQ-003 Parameter NREGS, default 11, number of architectural vector registers the writeback may target.
REQ-004 Clocking: one clock, clk; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-007 in_valid  in  1  operation presented this cycle.
REQ-008 in_ready  out  1  block can accept an operation this cycle.
REQ-009 op  in  3  operation code (see REQ-014).
REQ-010 dst  in  4  destination register index.
REQ-011 src_a  in  VW  first operand (register-file read port 1 data).
REQ-012 src_b  in  VW  second operand (register-file read port 2 data).
REQ-013 Writeback and status outputs:
- wb_we  out  1  write-enable pulse to the register file.
- wb_addr  out  4  write index.
- wb_data  out  VW  write data.
- bad_dst  out  1  one-cycle pulse on a rejected destination.

Function
REQ-014 Opcodes, lane-wise, lane i = bits [i*LANE_W +: LANE_W]:
- 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL (low LANE_W bits of product), 110 PASS (src_a).
- 111 NOP: accepted; no write; no bad_dst.
REQ-015 Arithmetic is modulo 2^LANE_W per lane; no carry or borrow crosses lane boundaries.
REQ-016 Transfer occurs only when in_valid && in_ready; operands, op and dst are captured at that edge, and later input changes have no effect.
REQ-017 FSM states IDLE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE, single-cycle op (000-100, 110) accepted in cycle N: wb_we = 1 in cycle N+1 with result; state stays IDLE, so back-to-back accepts give one write per cycle.
REQ-019 IDLE, MUL accepted in cycle N: state MUL for cycles N+1..N+LANES.
- Cycle N+1+k computes lane k with one LANE_W x LANE_W multiplier (lane counter 0..LANES-1).
REQ-020 MUL -> DONE after the lane counter reaches LANES-1; in DONE, wb_we = 1 for exactly one cycle (cycle N+LANES+1); DONE -> IDLE next cycle.
REQ-021 Outside the pulses of REQ-018/020, wb_we = 0; wb_addr and wb_data hold their last values.
REQ-022 dst >= NREGS: operation is consumed with normal timing, but wb_we stays 0 and bad_dst pulses in the cycle wb_we would have pulsed.
REQ-023 dst = 0 is a legal target.
REQ-024 No internal queue; an offer while in_ready = 0 is ignored, and the source must hold it.

Reset
REQ-025 On reset: state = IDLE, lane counter = 0, wb_we = 0, bad_dst = 0, wb_addr = 0, wb_data = 0, in_ready = 1 the cycle after reset deasserts.
REQ-026 Reset during MUL or DONE aborts the operation with no write and no bad_dst pulse.
REQ-027 Reset has priority over a simultaneous transfer; that operation is dropped.

Structure
REQ-028 Shared package vec_pkg holds:
- LANES, LANE_W, VW, NREGS constants.
- Opcode enum type vop_t.
- FSM state enum.
REQ-029 One sub-module, vec_lane_alu: combinational single-lane ADD/SUB/AND/OR/XOR/PASS, instantiated LANES times.
- The MUL datapath is one shared multiplier inside vec_execute.

Verification
REQ-030 ADD, src_a = 0xFF01_0203_0405, src_b = 0x0101_0101_0101, dst = 3 -> next cycle wb_we = 1, wb_addr = 3, wb_data = 0x0002_0304_0506 (lane-5 wrap, no carry into lane 4).
REQ-031 SUB, src_a = 0, src_b = 0x0000_0000_0001, dst = 1 -> wb_data = 0x0000_0000_00FF (per-lane borrow contained).
REQ-032 MUL, src_a = 0x0203_0405_1011, src_b = 0x0302_0203_1010, dst = 2:
- in_ready = 0 for 7 cycles.
- Single wb_we at N+7, wb_data = 0x0606_080F_0010.
REQ-033 XOR dst = 11 then AND dst = 10 back-to-back:
- Cycle N+1: bad_dst = 1, wb_we = 0.
- Cycle N+2: wb_we = 1, wb_addr = 10.
REQ-034 Reset asserted at cycle N+3 of a MUL -> no wb_we and no bad_dst afterward; in_ready = 1 the cycle after reset deasserts.
REQ-035 in_valid held with ADD while a MUL is in progress -> ADD accepted on the first IDLE cycle; its write follows the MUL write by exactly 2 cycles.
